// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer and arbiter for a 32-entry return/data stack held in an
// external synchronous single-port RAM. The interrupt unit (push/pop) and the
// core (call/ret) are served one operation at a time with fixed priority.
// Optional feature: define STACK_CTRL_WATERMARK_EN to add the max_sp output
// (highest occupancy reached since reset).
//
// state | meaning
// IDLE  | arbitrate pending requests, register the grant
// PUSH  | write granted word at sp, ack, sp+1
// RD    | read RAM at sp-1, sp-1
// CAP   | capture RAM read data into pop_data
// DONE  | ack and pop_valid pulse for a successful pop
// ERR   | push while full / pop while empty: ack only, set sticky flag
module stack_ctrl #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic [DATA_W-1:0]     call_data,
  input  logic                  ret_req,
  input  logic                  irq_push_req,
  input  logic [DATA_W-1:0]     irq_push_data,
  input  logic                  irq_pop_req,
  output logic                  core_ack,
  output logic                  irq_ack,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  pop_valid,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  busy
`ifdef STACK_CTRL_WATERMARK_EN
  ,
  output logic [DEPTH_LOG2:0]   max_sp
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH_V = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_RD, S_CAP, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] sp_q, sp_d;
  logic                src_irq_q, src_irq_d;
  logic                op_push_q, op_push_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                ack;
  logic                gnt_any, gnt_irq, gnt_push;
  logic [DATA_W-1:0]   gnt_data;
  logic [DEPTH_LOG2:0] sp_m1;

  // Fixed-priority request selection, only consumed in IDLE
  always_comb begin
    gnt_any  = 1'b1;
    gnt_irq  = 1'b0;
    gnt_push = 1'b0;
    gnt_data = '0;
    if (irq_push_req) begin
      gnt_irq  = 1'b1;
      gnt_push = 1'b1;
      gnt_data = irq_push_data;
    end else if (irq_pop_req) begin
      gnt_irq  = 1'b1;
    end else if (call_req) begin
      gnt_push = 1'b1;
      gnt_data = call_data;
    end else if (!ret_req) begin
      gnt_any  = 1'b0;
    end
  end

  // Next-state, datapath updates and RAM/handshake outputs
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    src_irq_d   = src_irq_q;
    op_push_d   = op_push_q;
    data_d      = data_q;
    pop_data_d  = pop_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ack         = 1'b0;
    pop_valid   = 1'b0;
    sp_m1       = sp_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          src_irq_d = gnt_irq;
          op_push_d = gnt_push;
          data_d    = gnt_data;
          if (gnt_push) begin
            state_d = full ? S_ERR : S_PUSH;
          end else if (empty) begin
            state_d    = S_ERR;
            pop_data_d = '0;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q[DEPTH_LOG2-1:0];
        mem_wdata = data_q;
        ack       = 1'b1;
        sp_d      = sp_q + 1'b1;
        state_d   = S_IDLE;
      end
      S_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_m1[DEPTH_LOG2-1:0];
        sp_d     = sp_m1;
        state_d  = S_CAP;
      end
      S_CAP: begin
        pop_data_d = mem_rdata;
        state_d    = S_DONE;
      end
      S_DONE: begin
        ack       = 1'b1;
        pop_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        ack = 1'b1;
        if (op_push_q) begin
          overflow_d = 1'b1;
        end else begin
          underflow_d = 1'b1;
          pop_valid   = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      src_irq_q   <= 1'b0;
      op_push_q   <= 1'b0;
      data_q      <= '0;
      pop_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      src_irq_q   <= src_irq_d;
      op_push_q   <= op_push_d;
      data_q      <= data_d;
      pop_data_q  <= pop_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef STACK_CTRL_WATERMARK_EN
  logic [DEPTH_LOG2:0] max_sp_q, max_sp_d;

  // Track the highest occupancy, one cycle behind sp
  always_comb begin
    max_sp_d = (sp_q > max_sp_q) ? sp_q : max_sp_q;
  end

  // Watermark register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) max_sp_q <= '0;
    else        max_sp_q <= max_sp_d;
  end

  assign max_sp = max_sp_q;
`endif

  assign core_ack  = ack & ~src_irq_q;
  assign irq_ack   = ack & src_irq_q;
  assign pop_data  = pop_data_q;
  assign sp        = sp_q;
  assign full      = (sp_q == DEPTH_V);
  assign empty     = (sp_q == '0);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencer and arbiter for the CPU's 32-entry, 10-bit return/data stack.
- Owns the stack pointer, full/empty status and error flags.
- Drives a separate synchronous stack RAM through a single read/write port.
- Arbitrates between two requesters, the interrupt unit (push/pop) and the core (call/ret), and returns popped data with a req/ack handshake.

Parameters:
DATA_W, 10, stack word width
DEPTH_LOG2, 5, log2 of stack depth (DEPTH = 2**DEPTH_LOG2 = 32)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
call_req  in  1  core push request (level, held until core_ack)
call_data  in  DATA_W  word to push for call
ret_req  in  1  core pop request (level, held until core_ack)
irq_push_req  in  1  interrupt-unit push request
irq_push_data  in  DATA_W  word to push for interrupt entry
irq_pop_req  in  1  interrupt-unit pop request
core_ack  out  1  one-cycle completion pulse to core
irq_ack  out  1  one-cycle completion pulse to interrupt unit
pop_data  out  DATA_W  popped word, valid while pop_valid=1
pop_valid  out  1  one-cycle pulse, coincident with the ack of a pop
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_addr  out  DEPTH_LOG2  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re
sp  out  DEPTH_LOG2+1  occupancy, 0..DEPTH
full  out  1  sp==DEPTH
empty  out  1  sp==0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; sp=0.
  - All acks, strobes, pop_valid, overflow and underflow = 0; pop_data=0; mem_addr=0; mem_wdata=0.
  - RAM contents are not cleared.
- FSM states: IDLE, PUSH, RD, CAP, DONE, ERR.
- Arbitration happens only in IDLE.
  - Fixed priority: irq_push_req > irq_pop_req > call_req > ret_req.
  - The grant (source, op, data) is registered at the IDLE edge.
  - Losers stay pending. No starvation guarantee beyond priority.
- Push, grant at cycle N:
  - Not full: N+1 = PUSH. mem_we=1, mem_addr=sp[DEPTH_LOG2-1:0], mem_wdata=granted data. Ack pulse to the granted source. sp<=sp+1. N+2 = IDLE.
  - Full: N+1 = ERR. Ack pulse, mem_we stays 0, sp unchanged, overflow<=1.
- Pop, grant at cycle N:
  - Not empty:
    - N+1 = RD: mem_re=1, mem_addr=sp-1, sp<=sp-1.
    - N+2 = CAP: pop_data<=mem_rdata.
    - N+3 = DONE: ack and pop_valid pulse. N+4 = IDLE.
  - Empty: N+1 = ERR. Ack and pop_valid pulse, pop_data=0, no mem_re, sp unchanged, underflow<=1.
- Handshake:
  - Acks are exactly one cycle.
  - Requester deasserts its req on the edge ending the ack cycle. Since the controller is back in IDLE only after that edge, no double service occurs.
  - Request data must be stable from assertion to ack.
- Core raising call_req and ret_req together: call served first, ret remains pending.
- A push and a pop never overlap. Throughput is one push per 2 cycles and one pop per 4 cycles.
- full/empty are combinational from sp. overflow/underflow clear only on reset.
- Reset mid-operation: the in-flight operation is abandoned with no ack. A push already in PUSH has completed its write, but sp returns to 0. Requesters must reissue.

Optional Feature:
- Macro STACK_CTRL_WATERMARK_EN.
- Defined: adds output max_sp (DEPTH_LOG2+1), the highest sp value reached since reset. It updates the cycle after sp increases and resets to 0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset: release reset -> sp=0, empty=1, full=0, overflow=underflow=0, busy=0, no strobes; assert reset mid-run -> same values immediately.
- call_data=0x155 call, then ret -> mem_we@N+1 addr 0 data 0x155, core_ack@N+1; on ret, mem_re addr 0, pop_data=0x155 with pop_valid and core_ack at N+3, sp back to 0.
- 32 calls with data 0..31 -> full=1, sp=32, max_sp=32 (macro on). 33rd call -> core_ack, overflow=1, no mem_we. 32 rets return 31 down to 0, then empty=1.
- ret on empty -> core_ack and pop_valid at N+1, pop_data=0, underflow=1, no mem_re, sp=0.
- irq_push_req(0x3FF) and call_req(0x001) asserted same cycle -> irq_ack first writes addr 0 = 0x3FF, then core_ack writes addr 1 = 0x001; irq_pop then returns 0x001.
- reset pulled low while FSM in RD of a pop -> no ack, busy=0, sp=0; after release, the reissued ret on empty sets underflow.
